// File: rtl/iddmm_sub.sv
// Final conditional subtraction of the word-serial IDDMM multiplier: compares {an,A} with M, streams A-M or A, then clears A RAM.
// Latency: task_req sampled in IDLE -> task_end 3N+3 cycles later; res_val words start 2 cycles after OUT address 0.
// Backpressure: none; once started the sequence runs to completion, retrigger blocked until task_req drops.
module iddmm_sub #(
  parameter int K      = 128,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              task_req,
  output logic              task_end,
  output logic [K-1:0]      res,
  output logic              res_val,
  output logic              clra_mem,
  output logic              clra_wren,
  output logic [ADDR_W-1:0] clra_addr,
  input  logic [K-1:0]      aj,
  input  logic [K-1:0]      an,
  input  logic [K-1:0]      mj,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_m
);

  localparam int CW = ADDR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_CMPW, S_OUT, S_CLR, S_END, S_HOLD
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           borrow_q, borrow_d;
  logic           sel_q, sel_d;
  logic           vld_q, vld_d;
  logic [K-1:0]   res_q, res_d;
  logic           res_val_q, res_val_d;
  logic           task_end_q, task_end_d;

  // word difference including incoming borrow; bit K is the outgoing borrow
  logic [K:0]     diff;
  logic           unused_an;

  assign diff      = {1'b0, aj} - {1'b0, mj} - {{K{1'b0}}, borrow_q};
  assign unused_an = ^an[K-1:1];

  assign addr_a    = cnt_q[ADDR_W-1:0];
  assign addr_m    = cnt_q[ADDR_W-1:0];
  assign clra_mem  = (state_q == S_CLR);
  assign clra_wren = (state_q == S_CLR);
  assign clra_addr = (state_q == S_CLR) ? cnt_q[ADDR_W-1:0] : '0;
  assign res       = res_q;
  assign res_val   = res_val_q;
  assign task_end  = task_end_q;

  // next-state, counter and datapath decisions
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    borrow_d   = borrow_q;
    sel_d      = sel_q;
    res_d      = res_q;
    res_val_d  = 1'b0;
    task_end_d = 1'b0;
    // a read issued this cycle returns data next cycle; the OUT drain cycle issues none
    vld_d      = (state_q == S_CMP) || ((state_q == S_OUT) && (cnt_q != CW'(N)));
    case (state_q)
      S_IDLE: begin
        cnt_d    = '0;
        borrow_d = 1'b0;
        if (task_req) state_d = S_CMP;
      end
      S_CMP: begin
        if (vld_q) borrow_d = diff[K];
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_CMPW;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CMPW: begin
        // last word's borrow decides A < M; overflow bit forces subtraction
        sel_d    = an[0] | ~diff[K];
        borrow_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (vld_q) begin
          res_val_d = 1'b1;
          if (sel_q) begin
            res_d    = diff[K-1:0];
            borrow_d = diff[K];
          end else begin
            res_d = aj;
          end
        end
        if (cnt_q == CW'(N)) begin
          cnt_d   = '0;
          state_d = S_CLR;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_CLR: begin
        if (cnt_q == CW'(N - 1)) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_END: begin
        task_end_d = 1'b1;
        state_d    = S_HOLD;
      end
      S_HOLD: begin
        if (!task_req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      borrow_q   <= 1'b0;
      sel_q      <= 1'b0;
      vld_q      <= 1'b0;
      res_q      <= '0;
      res_val_q  <= 1'b0;
      task_end_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      borrow_q   <= borrow_d;
      sel_q      <= sel_d;
      vld_q      <= vld_d;
      res_q      <= res_d;
      res_val_q  <= res_val_d;
      task_end_q <= task_end_d;
    end
  end

endmodule

// File: tb/tb_iddmm_sub.sv
// Bench for iddmm_sub: synchronous A/M RAM models, big-integer reference of the conditional subtraction.
// Checks result words, clear sequence, completion latency, retrigger block and async reset.
// Inputs driven on negedge, outputs sampled 1 time unit after posedge.
module tb_iddmm_sub;
  localparam int K  = 128;
  localparam int N  = 16;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          task_req = 1'b0;
  logic          task_end;
  logic [K-1:0]  res;
  logic          res_val;
  logic          clra_mem, clra_wren;
  logic [AW-1:0] clra_addr, addr_a, addr_m;
  logic [K-1:0]  aj, mj, an;

  logic [K-1:0]  a_mem  [N];
  logic [K-1:0]  a_init [N];
  logic [K-1:0]  m_mem  [N];
  logic [K-1:0]  exp_w  [N];
  logic [K-1:0]  got_w  [N];
  logic          load_req = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iddmm_sub #(.K(K), .N(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .task_req(task_req), .task_end(task_end),
    .res(res), .res_val(res_val), .clra_mem(clra_mem), .clra_wren(clra_wren),
    .clra_addr(clra_addr), .aj(aj), .an(an), .mj(mj),
    .addr_a(addr_a), .addr_m(addr_m)
  );

  // synchronous RAMs with one cycle read latency; A RAM is cleared through the DUT write port
  always @(posedge clk) begin
    aj <= a_mem[addr_a];
    mj <= m_mem[addr_m];
    if (load_req) begin
      for (int i = 0; i < N; i++) a_mem[i] <= a_init[i];
    end else if (clra_wren) begin
      a_mem[clra_addr] <= '0;
    end
  end

  task automatic chk(input string tag, input logic [K-1:0] got, input logic [K-1:0] expv);
    vectors++;
    if (got !== expv) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, expv);
    end
  endtask

  function automatic logic [K-1:0] rnd_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // reference: treat {an,A} and M as plain integers
  task automatic build_expect();
    logic [K*N:0] abig, mbig, rbig;
    abig = '0;
    mbig = '0;
    for (int i = 0; i < N; i++) begin
      abig[i*K +: K] = a_init[i];
      mbig[i*K +: K] = m_mem[i];
    end
    abig[K*N] = an[0];
    rbig = (abig >= mbig) ? abig - mbig : abig;
    for (int i = 0; i < N; i++) exp_w[i] = rbig[i*K +: K];
  endtask

  task automatic load_a();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic run_op(input string tag, input int hold);
    int nres, nclr, lat;
    logic bad_addr, bad_clr, bad_hold;
    logic [K-1:0] acc;
    build_expect();
    load_a();
    nres = 0; nclr = 0; lat = -1;
    bad_addr = 1'b0; bad_clr = 1'b0; bad_hold = 1'b0;
    task_req = 1'b1;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (addr_a !== addr_m) bad_addr = 1'b1;
      if (res_val) begin
        if (nres < N) got_w[nres] = res;
        nres++;
      end
      if (clra_wren) begin
        if (!clra_mem || clra_addr != AW'(nclr)) bad_clr = 1'b1;
        nclr++;
      end
      if (task_end) begin
        lat = k;
        break;
      end
    end
    chk({tag, " latency"}, K'(lat), K'(3*N + 3));
    chk({tag, " res count"}, K'(nres), K'(N));
    for (int i = 0; i < N && i < nres; i++) chk($sformatf("%s word%0d", tag, i), got_w[i], exp_w[i]);
    chk({tag, " clr count"}, K'(nclr), K'(N));
    chk({tag, " clr seq"}, K'(bad_clr), K'(0));
    chk({tag, " addr eq"}, K'(bad_addr), K'(0));
    chk({tag, " res hold"}, res, exp_w[N-1]);
    // request still high: nothing may start again
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (task_end || res_val || clra_mem || addr_a != '0) bad_hold = 1'b1;
    end
    if (hold > 0) chk({tag, " no retrigger"}, K'(bad_hold), K'(0));
    @(negedge clk);
    task_req = 1'b0;
    @(negedge clk);
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc | a_mem[i];
    chk({tag, " A cleared"}, acc, '0);
  endtask

  task automatic fill_m_rand();
    for (int i = 0; i < N; i++) m_mem[i] = rnd_word();
  endtask

  initial begin
    logic [K-1:0] ones;
    int waited;
    ones = '1;
    an = '0;
    for (int i = 0; i < N; i++) begin
      a_init[i] = '0;
      m_mem[i]  = '0;
    end
    #1;
    chk("rst res", res, '0);
    chk("rst ctl", K'({task_end, res_val, clra_mem, clra_wren}), '0);
    chk("rst addr", K'({clra_addr, addr_a, addr_m}), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // A = M-1, no subtraction
    fill_m_rand();
    m_mem[0][K-1] = 1'b1;
    for (int i = 0; i < N; i++) a_init[i] = m_mem[i];
    a_init[0] = m_mem[0] - 1;
    run_op("a_lt_m", 5);

    // A = M+5
    for (int i = 0; i < N; i++) a_init[i] = m_mem[i];
    m_mem[0][K-1:K-8] = 8'h00;
    a_init[0] = m_mem[0] + 5;
    run_op("a_m5", 0);

    // A == M
    for (int i = 0; i < N; i++) a_init[i] = m_mem[i];
    run_op("a_eq_m", 0);

    // overflow forces subtraction: 2^2048 + 1 - 2
    for (int i = 0; i < N; i++) begin
      a_init[i] = '0;
      m_mem[i]  = '0;
    end
    a_init[0] = 1;
    m_mem[0]  = 2;
    an = {ones[K-1:1], 1'b1};
    run_op("forced", 0);
    chk("forced all ones", exp_w[5], ones);
    an = '0;

    // borrow ripples across a word boundary
    for (int i = 0; i < N; i++) begin
      a_init[i] = '0;
      m_mem[i]  = '0;
    end
    a_init[1] = 1;
    m_mem[0]  = 1;
    run_op("borrow", 0);

    // randomized operands, A above and below M, with overflow bit
    for (int r = 0; r < 6; r++) begin
      fill_m_rand();
      for (int i = 0; i < N; i++) a_init[i] = rnd_word();
      if (r % 3 == 0) a_init[N-1] = m_mem[N-1];
      an = {rnd_word() & ~K'(1), ($urandom_range(0, 3) == 0)};
      run_op($sformatf("rand%0d", r), (r == 1) ? 3 : 0);
    end
    an = '0;

    // asynchronous reset in the middle of the output pass
    fill_m_rand();
    for (int i = 0; i < N; i++) a_init[i] = rnd_word();
    load_a();
    task_req = 1'b1;
    waited = 0;
    for (int k = 0; k < 200 && waited < 3; k++) begin
      @(posedge clk); #1;
      if (res_val) waited++;
    end
    chk("reached OUT", K'(waited), K'(3));
    #1 rst_n = 1'b0;
    #1;
    chk("mid rst res", res, '0);
    chk("mid rst ctl", K'({task_end, res_val, clra_mem, clra_wren}), '0);
    chk("mid rst addr", K'({clra_addr, addr_a, addr_m}), '0);
    task_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after rst", 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
